// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO registers, accumulate modes and stall request.
// The result is computed at launch and held in pending regs until the busy window ends.
module md_unit_param #(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [2:0]   mdop,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [W-1:0] wdata,
  input  logic         usemd,
  output logic         busy,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_L = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_L  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [W-1:0]  ONE_W  = W'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] pend;
  logic           pend_we;

  // mdop[0] set selects the unsigned flavour of every op
  logic           sgn, is_div, a_neg, b_neg, wb;
  logic [2*W-1:0] ea, eb, prod, acc, res;
  logic [W-1:0]   ua, ub, ubs, uq, ur, q, r;

  always_comb begin
    sgn    = ~mdop[0];
    is_div = (mdop[2:1] == 2'b01);
    ea     = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb     = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod   = ea * eb;
    acc    = {hi, lo};
    a_neg  = sgn & a[W-1];
    b_neg  = sgn & b[W-1];
    ua     = a_neg ? -a : a;
    ub     = b_neg ? -b : b;
    // divisor forced to 1 on zero so the divider never sees x/0; result is discarded
    ubs    = (b == '0) ? ONE_W : ub;
    uq     = ua / ubs;
    ur     = ua % ubs;
    q      = (a_neg ^ b_neg) ? -uq : uq;
    r      = a_neg ? -ur : ur;
    wb     = !(is_div && (b == '0));
    case (mdop[2:1])
      2'b00:   res = prod;
      2'b01:   res = {r, q};
      2'b10:   res = acc + prod;
      default: res = acc - prod;
    endcase
  end

  assign stall = usemd & (busy | start);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend    <= res;
            pend_we <= wb;
            cnt     <= is_div ? DIV_L : MULT_L;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
          end
        end
        RUN: begin
          if (cnt == ONE_C) begin
            if (pend_we) {hi, lo} <= pend;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit_param.sv
// Directed self-checking bench for md_unit_param at W=32, 5 mult / 10 div cycles.
module tb_md_unit_param;
  logic        clk, clr, start, we_hi, we_lo, usemd;
  logic [2:0]  mdop;
  logic [31:0] a, b, wdata;
  logic        busy, stall;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_err = 0;

  md_unit_param #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .clr(clr), .start(start), .mdop(mdop), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata), .usemd(usemd),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    mdop = op; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_hl(input logic wh, input logic wl, input logic [31:0] d);
    we_hi = wh; we_lo = wl; wdata = d;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
  endtask

  task automatic test_reset();
    clr = 1'b1; tick(); tick(); clr = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h exp 0", lo); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", stall); end
  endtask

  task automatic test_mult();
    int n;
    bit bad;
    mdop = 3'd0; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1; usemd = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall_on_start: got %b exp 1", stall); end
    tick(); start = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 50) begin
      if (stall !== 1'b1 || hi !== 32'h0 || lo !== 32'h0) bad = 1;
      n++; tick();
    end
    usemd = 1'b0;
    n_cmp++; if (bad) begin n_err++; $display("FAIL mult_run_stall_hold: stall/hi/lo changed during run exp stall=1 hi=lo=0"); end
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL mult_busy_cycles: got %0d exp 5", n); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h exp ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo: got %h exp ffffffeb", lo); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b exp 0", stall); end
  endtask

  task automatic test_multu();
    int n;
    launch(3'd1, 32'hFFFFFFFF, 32'd2); wait_done(n);
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL multu_busy_cycles: got %0d exp 5", n); end
    n_cmp++; if (hi !== 32'h1) begin n_err++; $display("FAIL multu_hi: got %h exp 00000001", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo: got %h exp fffffffe", lo); end
  endtask

  task automatic test_div();
    int n;
    launch(3'd2, 32'hFFFFFFF9, 32'd2); wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_busy_cycles: got %0d exp 10", n); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h exp fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h exp ffffffff", hi); end
    launch(3'd3, 32'd7, 32'd0); wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL divz_busy_cycles: got %0d exp 10", n); end
    n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL divz_keep: got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo); end
    launch(3'd2, 32'd7, 32'hFFFFFFFE); wait_done(n);
    n_cmp++; if (lo !== 32'hFFFFFFFD || hi !== 32'h1) begin n_err++; $display("FAIL div_negb: got hi=%h lo=%h exp hi=00000001 lo=fffffffd", hi, lo); end
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_done(n);
    n_cmp++; if (lo !== 32'h80000000 || hi !== 32'h0) begin n_err++; $display("FAIL div_min_m1: got hi=%h lo=%h exp hi=00000000 lo=80000000", hi, lo); end
    launch(3'd3, 32'hFFFFFFF9, 32'd2); wait_done(n);
    n_cmp++; if (lo !== 32'h7FFFFFFC || hi !== 32'h1) begin n_err++; $display("FAIL divu: got hi=%h lo=%h exp hi=00000001 lo=7ffffffc", hi, lo); end
  endtask

  task automatic test_accum();
    int n;
    write_hl(1'b1, 1'b0, 32'h0);
    write_hl(1'b0, 1'b1, 32'd5);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'd5) begin n_err++; $display("FAIL mthi_mtlo: got hi=%h lo=%h exp hi=00000000 lo=00000005", hi, lo); end
    launch(3'd4, 32'd2, 32'd3); wait_done(n);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'd11) begin n_err++; $display("FAIL madd: got hi=%h lo=%h exp hi=00000000 lo=0000000b", hi, lo); end
    launch(3'd7, 32'd1, 32'd12);
    we_hi = 1'b1; wdata = 32'h1234;   // write attempt while busy must be ignored
    tick(); we_hi = 1'b0;
    wait_done(n);
    n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL msubu: got hi=%h lo=%h exp hi=ffffffff lo=ffffffff", hi, lo); end
    launch(3'd6, 32'hFFFFFFFF, 32'd3); wait_done(n);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'd2) begin n_err++; $display("FAIL msub: got hi=%h lo=%h exp hi=00000000 lo=00000002", hi, lo); end
    // start and mtlo together: start wins
    we_lo = 1'b1; wdata = 32'hDEAD;
    launch(3'd1, 32'd4, 32'd4);
    we_lo = 1'b0;
    wait_done(n);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'd16) begin n_err++; $display("FAIL start_beats_we: got hi=%h lo=%h exp hi=00000000 lo=00000010", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    usemd = 1'b1;
    launch(3'd0, 32'd2, 32'd3);
    mdop = 3'd1; a = 32'd5; b = 32'd5; start = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b exp 1", stall); end
    tick(); start = 1'b0;
    wait_done(n);
    usemd = 1'b0;
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL b2b_remaining_busy: got %0d exp 4", n); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'd6) begin n_err++; $display("FAIL b2b_result: got hi=%h lo=%h exp hi=00000000 lo=00000006", hi, lo); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_queue: got busy=%b exp 0", busy); end
  endtask

  task automatic test_clr_mid();
    bit bad;
    launch(3'd2, 32'd100, 32'd7);
    tick(); tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL clr_mid: got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad = 1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL clr_late_wb: got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mdop = '0; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; wdata = '0; usemd = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_accum();
    test_back_to_back();
    test_clr_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
